lm_head_argmax: RTL and testbench

Final output stage downstream of the transformer decoder stack. It consumes one hidden vector and computes logits against every row of the token-embedding table (weight-tied LM head). Rows are streamed one per cycle from an external synchronous memory, and the block tracks the running maximum. It emits the greedy next-token index and its logit.

---
 rtl/lm_head_argmax.sv | 205 ++++++++++++++++++++
 tb/tb_lm_head_argmax.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lm_head_argmax.sv
// -----------------------------------------------------------------------------
// lm_head_argmax
//
// Greedy next-token picker for a weight-tied LM head. A hidden vector is
// latched, every row of the token-embedding table is read (one per cycle)
// from an external synchronous memory, and the row with the largest signed
// dot product against the hidden vector wins. The winning index and its
// logit (rescaled to the element format and saturated) are then presented
// together with a one-cycle strobe.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   valid_in   : x_in valid, only looked at while idle
//   x_in       : hidden vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wte_rd_en  : embedding memory read strobe
//   wte_addr   : embedding row address (always < VOCAB_SIZE)
//   wte_rdata  : row data, valid in the cycle after a read is issued
//   busy       : high whenever a lookup is in progress
//   token_out  : argmax row index (held until the next result)
//   logit_out  : winning logit >>> FRAC_BITS, saturated to DATA_WIDTH
//   valid_out  : one-cycle result strobe
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for valid_in, outputs hold the previous result
//   S_FETCH | one row read per cycle, addresses 0..VOCAB_SIZE-1
//   S_DRAIN | last row returns and is compared, result registered
//   S_DONE  | valid_out high for this single cycle
// -----------------------------------------------------------------------------
module lm_head_argmax #(
    parameter int EMBED_DIM  = 4,
    parameter int VOCAB_SIZE = 8,
    parameter int IDX_WIDTH  = 3,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_in,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0] x_in,
    output logic                            wte_rd_en,
    output logic [IDX_WIDTH-1:0]            wte_addr,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0] wte_rdata,
    output logic                            busy,
    output logic [IDX_WIDTH-1:0]            token_out,
    output logic [DATA_WIDTH-1:0]           logit_out,
    output logic                            valid_out
);

    localparam int                   PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_ADDR  = IDX_WIDTH'(VOCAB_SIZE - 1);

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] LOGIT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] LOGIT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          state_q;
    logic [EMBED_DIM*DATA_WIDTH-1:0] x_q;
    logic                            rd_en_q;
    logic [IDX_WIDTH-1:0]            addr_q;
    logic                            row_vld_q;
    logic [IDX_WIDTH-1:0]            row_idx_q;
    logic signed [ACC_WIDTH-1:0]     max_acc_q;
    logic signed [ACC_WIDTH-1:0]     max_acc_d;
    logic [IDX_WIDTH-1:0]            max_idx_q;
    logic [IDX_WIDTH-1:0]            max_idx_d;
    logic                            busy_q;
    logic                            valid_q;
    logic [IDX_WIDTH-1:0]            token_q;
    logic [DATA_WIDTH-1:0]           logit_q;

    logic signed [ACC_WIDTH-1:0]     dot;
    logic signed [ACC_WIDTH-1:0]     shifted;
    logic [DATA_WIDTH-1:0]           logit_sat;

    // ------------------------------------------------------------------
    // Dot product of the latched hidden vector with the returning row.
    // Full-precision products, sign-extended before summation.
    // ------------------------------------------------------------------
    always_comb begin
        logic signed [DATA_WIDTH-1:0] xe;
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [PROD_WIDTH-1:0] prod;
        dot  = '0;
        xe   = '0;
        re   = '0;
        prod = '0;
        for (int i = 0; i < EMBED_DIM; i++) begin
            xe   = x_q[i*DATA_WIDTH +: DATA_WIDTH];
            re   = wte_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            prod = xe * re;
            dot  = dot + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
        end
    end

    // ------------------------------------------------------------------
    // Running maximum. Row 0 always seeds the maximum so an all-negative
    // table still reports its true best row; later rows need to be
    // strictly larger, which keeps the lowest index on ties.
    // ------------------------------------------------------------------
    always_comb begin
        max_acc_d = max_acc_q;
        max_idx_d = max_idx_q;
        if (row_vld_q && ((row_idx_q == '0) || (dot > max_acc_q))) begin
            max_acc_d = dot;
            max_idx_d = row_idx_q;
        end
    end

    // Rescale the (possibly just-updated) maximum to the element format.
    // The arithmetic shift truncates toward minus infinity.
    always_comb begin
        shifted = max_acc_d >>> FRAC_BITS;
        if (shifted > LOGIT_MAX) begin
            logit_sat = LOGIT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < LOGIT_MIN) begin
            logit_sat = LOGIT_MIN[DATA_WIDTH-1:0];
        end else begin
            logit_sat = shifted[DATA_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            row_vld_q <= 1'b0;
            row_idx_q <= '0;
            max_acc_q <= '0;
            max_idx_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            token_q   <= '0;
            logit_q   <= '0;
        end else begin
            // Memory returns data one cycle after the read, so the row
            // index simply trails the issued address by a cycle.
            row_vld_q <= rd_en_q;
            row_idx_q <= addr_q;
            max_acc_q <= max_acc_d;
            max_idx_q <= max_idx_d;

            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        x_q     <= x_in;
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (addr_q == LAST_ADDR) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + IDX_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    // Last row is compared on this edge, so take the
                    // result from the next-state maximum.
                    token_q <= max_idx_d;
                    logit_q <= logit_sat;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wte_rd_en = rd_en_q;
    assign wte_addr  = addr_q;
    assign busy      = busy_q;
    assign valid_out = valid_q;
    assign token_out = token_q;
    assign logit_out = logit_q;

endmodule

// File: tb/tb_lm_head_argmax.sv
// Self-checking bench for lm_head_argmax at default parameters.
module tb_lm_head_argmax;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [63:0] x_in;
    logic        wte_rd_en;
    logic [2:0]  wte_addr;
    logic [63:0] wte_rdata;
    logic        busy;
    logic [2:0]  token_out;
    logic [15:0] logit_out;
    logic        valid_out;

    int checks;
    int errors;

    logic [63:0] mem [8];

    typedef struct {
        string           name;
        logic [63:0]     x;
        logic [7:0][63:0] rows;
        logic [2:0]      tok;
        logic [15:0]     logit;
    } vec_t;

    vec_t vecs [8];

    lm_head_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .x_in      (x_in),
        .wte_rd_en (wte_rd_en),
        .wte_addr  (wte_addr),
        .wte_rdata (wte_rdata),
        .busy      (busy),
        .token_out (token_out),
        .logit_out (logit_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous embedding memory; junk is returned when not read so any
    // use of wte_rdata outside a return cycle corrupts the result.
    always @(posedge clk) begin
        if (wte_rd_en) wte_rdata <= mem[wte_addr];
        else           wte_rdata <= {$urandom, $urandom};
    end

    function automatic logic [63:0] pk(input int e0, input int e1, input int e2, input int e3);
        logic [15:0] a, b, c, d;
        a = 16'(e0); b = 16'(e1); c = 16'(e2); d = 16'(e3);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input int v);
        for (int r = 0; r < 8; r++) mem[r] = vecs[v].rows[r];
    endtask

    task automatic run_vec(input int v);
        int lat, n_rd, n_busy;
        bit addr_ok;
        load_mem(v);
        @(negedge clk);
        x_in     = vecs[v].x;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        lat = -1; n_rd = 0; n_busy = 0; addr_ok = 1'b1;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            if (wte_rd_en) begin
                if (wte_addr != 3'(n_rd)) addr_ok = 1'b0;
                n_rd++;
            end
            if (busy) n_busy++;
            if (valid_out) lat = c;
            else @(negedge clk);
        end
        check({vecs[v].name, " latency"}, 64'(lat), 64'd10);
        check({vecs[v].name, " token"}, 64'(token_out), 64'(vecs[v].tok));
        check({vecs[v].name, " logit"}, 64'(logit_out), 64'(vecs[v].logit));
        check({vecs[v].name, " rd_en count"}, 64'(n_rd), 64'd8);
        check({vecs[v].name, " addr order"}, 64'(addr_ok), 64'd1);
        check({vecs[v].name, " busy count"}, 64'(n_busy), 64'd10);
        @(negedge clk);
        check({vecs[v].name, " strobe width"}, 64'(valid_out), 64'd0);
        check({vecs[v].name, " token hold"}, 64'(token_out), 64'(vecs[v].tok));
    endtask

    initial begin
        int pulses [$];
        bit stable, seen, found;
        checks = 0; errors = 0;
        rst = 1'b1; valid_in = 1'b0; x_in = '0;
        for (int r = 0; r < 8; r++) mem[r] = '0;

        // Vector table
        vecs[0].name = "basic"; vecs[0].x = pk(256, 0, 0, 0);
        for (int r = 0; r < 8; r++) vecs[0].rows[r] = pk(r * 32, 0, 0, 0);
        vecs[0].rows[5] = pk(768, 0, 0, 0);
        vecs[0].tok = 3'd5; vecs[0].logit = 16'd768;

        vecs[1].name = "tie"; vecs[1].x = pk(256, 0, 0, 0);
        vecs[1].rows[0] = pk(0, 0, 0, 0);   vecs[1].rows[1] = pk(100, 0, 0, 0);
        vecs[1].rows[2] = pk(256, 0, 0, 0); vecs[1].rows[3] = pk(-5, 0, 0, 0);
        vecs[1].rows[4] = pk(200, 0, 0, 0); vecs[1].rows[5] = pk(255, 0, 0, 0);
        vecs[1].rows[6] = pk(256, 0, 0, 0); vecs[1].rows[7] = pk(10, 0, 0, 0);
        vecs[1].tok = 3'd2; vecs[1].logit = 16'd256;

        vecs[2].name = "all_negative"; vecs[2].x = pk(256, 0, 0, 0);
        for (int r = 0; r < 8; r++) vecs[2].rows[r] = pk(-512, 0, 0, 0);
        vecs[2].rows[7] = pk(-256, 0, 0, 0);
        vecs[2].tok = 3'd7; vecs[2].logit = 16'hFF00;

        vecs[3].name = "sat_pos"; vecs[3].x = pk(32767, 32767, 32767, 32767);
        for (int r = 0; r < 8; r++) vecs[3].rows[r] = pk(32767, 32767, 32767, 32767);
        vecs[3].tok = 3'd0; vecs[3].logit = 16'h7FFF;

        vecs[4].name = "sat_neg"; vecs[4].x = pk(32767, 32767, 32767, 32767);
        for (int r = 0; r < 8; r++) vecs[4].rows[r] = pk(-32768, -32768, -32768, -32768);
        vecs[4].tok = 3'd0; vecs[4].logit = 16'h8000;

        // Multi-element dot products; rows 6 and 7 tie at 458752 -> 1792.
        vecs[5].name = "multi_elem"; vecs[5].x = pk(256, 512, 0, -256);
        vecs[5].rows[0] = pk(0, 0, 0, 0);        vecs[5].rows[1] = pk(256, 0, 0, 0);
        vecs[5].rows[2] = pk(0, 0, 12345, 0);    vecs[5].rows[3] = pk(0, 768, 0, 0);
        vecs[5].rows[4] = pk(0, 0, 0, -1024);    vecs[5].rows[5] = pk(256, 256, 0, 256);
        vecs[5].rows[6] = pk(-256, 0, 0, -2048); vecs[5].rows[7] = pk(1792, 0, 0, 0);
        vecs[5].tok = 3'd6; vecs[5].logit = 16'd1792;

        // dot = -1 everywhere: shift floors to -1, tie keeps row 0.
        vecs[6].name = "floor_shift"; vecs[6].x = pk(1, 0, 0, 0);
        for (int r = 0; r < 8; r++) vecs[6].rows[r] = pk(-1, 0, 0, 0);
        vecs[6].tok = 3'd0; vecs[6].logit = 16'hFFFF;

        vecs[7].name = "row0_max"; vecs[7].x = pk(256, 0, 0, 0);
        for (int r = 0; r < 8; r++) vecs[7].rows[r] = pk(r * 10, 0, 0, 0);
        vecs[7].rows[0] = pk(1000, 0, 0, 0);
        vecs[7].tok = 3'd0; vecs[7].logit = 16'd1000;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset rd_en", 64'(wte_rd_en), 64'd0);
        check("reset addr", 64'(wte_addr), 64'd0);
        check("reset token", 64'(token_out), 64'd0);
        check("reset logit", 64'(logit_out), 64'd0);
        check("reset valid", 64'(valid_out), 64'd0);

        for (int v = 0; v < 8; v++) run_vec(v);

        // valid_in held high: results every 11 cycles, outputs stable.
        load_mem(0);
        @(negedge clk);
        x_in = vecs[0].x;
        valid_in = 1'b1;
        stable = 1'b1; seen = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (valid_out) begin
                pulses.push_back(c);
                seen = 1'b1;
            end
            if (seen && (token_out != 3'd5 || logit_out != 16'd768)) stable = 1'b0;
        end
        valid_in = 1'b0;
        check("hold pulse count", 64'(pulses.size()), 64'd4);
        if (pulses.size() >= 1) check("hold first latency", 64'(pulses[0]), 64'd10);
        for (int i = 1; i < pulses.size(); i++)
            check("hold spacing", 64'(pulses[i] - pulses[i-1]), 64'd11);
        check("hold stable", 64'(stable), 64'd1);
        repeat (15) @(negedge clk);

        // Reset in the middle of FETCH
        load_mem(1);
        @(negedge clk);
        x_in = vecs[1].x;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (wte_rd_en && wte_addr == 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("mid reset reached addr 3", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset rd_en", 64'(wte_rd_en), 64'd0);
        check("mid reset token", 64'(token_out), 64'd0);
        check("mid reset logit", 64'(logit_out), 64'd0);
        check("mid reset valid", 64'(valid_out), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (valid_out || busy) seen = 1'b1;
        end
        check("no result after reset", 64'(seen), 64'd0);
        run_vec(1);
        run_vec(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
